// File: rtl/uart_tx.sv
// UART transmitter: start bit, eight data bits LSB first, optional parity bit, stop bit.
// Define UART_TX_PARITY_EN to include the parity bit (^din ^ PARITY) in every frame.
module uart_tx #(
    parameter int CLK_FREQUENCY = 100_000_000,
    parameter int BAUD_RATE     = 19_200,
    parameter bit PARITY        = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send,
    input  logic [7:0] din,
    output logic       busy,
    output logic       done,
    output logic       tx_out
);

    localparam int BAUD_CLOCK_CYCLES = CLK_FREQUENCY / BAUD_RATE;
    localparam int CNT_W = (BAUD_CLOCK_CYCLES > 1) ? $clog2(BAUD_CLOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CLOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(BAUD_CLOCK_CYCLES - 2);
    localparam bit SINGLE_CYCLE_BIT = (BAUD_CLOCK_CYCLES == 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP
`ifdef UART_TX_PARITY_EN
        , PARITY_BIT
`endif
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic             bit_end;

`ifdef UART_TX_PARITY_EN
    logic parity_reg;
`else
    logic unused_parity;
    assign unused_parity = PARITY;
`endif

    assign bit_end = (baud_cnt == CNT_LAST);

    // done is registered, so it is raised one cycle early to land on the last stop cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
`ifdef UART_TX_PARITY_EN
            parity_reg <= 1'b0;
`endif
            tx_out    <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    done     <= 1'b0;
                    if (send) begin
                        state     <= START;
                        shift_reg <= din;
                        bit_idx   <= '0;
                        busy      <= 1'b1;
                        tx_out    <= 1'b0;
`ifdef UART_TX_PARITY_EN
                        parity_reg <= ^din ^ PARITY;
`endif
                    end else begin
                        busy   <= 1'b0;
                        tx_out <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state    <= DATA;
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx_out   <= shift_reg[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt  <= '0;
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        bit_idx   <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state  <= PARITY_BIT;
                            tx_out <= parity_reg;
`else
                            state  <= STOP;
                            tx_out <= 1'b1;
                            done   <= SINGLE_CYCLE_BIT;
`endif
                        end else begin
                            tx_out <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY_BIT: begin
                    if (bit_end) begin
                        state    <= STOP;
                        baud_cnt <= '0;
                        tx_out   <= 1'b1;
                        done     <= SINGLE_CYCLE_BIT;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        state    <= IDLE;
                        baud_cnt <= '0;
                        busy     <= 1'b0;
                        done     <= 1'b0;
                        tx_out   <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                        done     <= (baud_cnt == CNT_DONE);
                    end
                end
                default: begin
                    state  <= IDLE;
                    tx_out <= 1'b1;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame-level reference model plus table-driven and corner-case sequences.
module tb_uart_tx;

    localparam int CLK_F = 1300;
    localparam int BAUD  = 100;
    localparam int B     = CLK_F / BAUD;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FC = FRAME_BITS * B;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       send = 1'b0;
    logic [7:0] din = 8'h00;
    logic       busy;
    logic       done;
    logic       tx_out;

    int checks = 0;
    int failures = 0;

    uart_tx #(
        .CLK_FREQUENCY(CLK_F),
        .BAUD_RATE    (BAUD),
        .PARITY       (1'b1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .send  (send),
        .din   (din),
        .busy  (busy),
        .done  (done),
        .tx_out(tx_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] din;
        logic       exp_parity;
    } vec_t;

    vec_t vecs[6];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Line content in transmit order: index 0 is the start bit, the rest default to idle/stop high
    function automatic logic [10:0] frame_of(input logic [7:0] d);
        logic [10:0] f;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
`ifdef UART_TX_PARITY_EN
        f[9] = ^d ^ 1'b1;
`endif
        return f;
    endfunction

    logic        m_active = 1'b0;
    int          m_k = 0;
    logic [10:0] m_frame = '1;
    logic        mon_en = 1'b0;
    logic        exp_tx, exp_busy, exp_done;

    always @(posedge clk) begin
        if (!rst) begin
            m_active <= 1'b0;
            m_k      <= 0;
        end else if (m_active) begin
            if (m_k == FC - 1) begin
                m_active <= 1'b0;
                m_k      <= 0;
            end else begin
                m_k <= m_k + 1;
            end
        end else if (send) begin
            m_active <= 1'b1;
            m_k      <= 0;
            m_frame  <= frame_of(din);
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            exp_tx   = m_active ? m_frame[m_k / B] : 1'b1;
            exp_busy = m_active;
            exp_done = m_active && (m_k == FC - 1);
            check_output("cycle", 32'({tx_out, busy, done}), 32'({exp_tx, exp_busy, exp_done}));
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 2 * FC) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2 * FC) check_output("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic apply_stimulus(input vec_t v);
        logic [10:0] exp_frame;
        int busy_cycles, done_cycles, done_at;
        exp_frame = '1;
        exp_frame[0] = 1'b0;
        exp_frame[8:1] = v.din;
`ifdef UART_TX_PARITY_EN
        exp_frame[9] = v.exp_parity;
`endif
        wait_idle();
        din  = v.din;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        busy_cycles = 0;
        done_cycles = 0;
        done_at = -1;
        for (int k = 0; k < FC + 2; k++) begin
            if ((k % B) == (B / 2) && (k / B) < FRAME_BITS)
                check_output($sformatf("bit%0d_of_%02h", k / B, v.din), 32'(tx_out), 32'(exp_frame[k / B]));
            if (busy) busy_cycles++;
            if (done) begin
                done_cycles++;
                done_at = k;
            end
            @(negedge clk);
        end
        check_output($sformatf("busy_len_%02h", v.din), busy_cycles, FC);
        check_output($sformatf("done_count_%02h", v.din), done_cycles, 1);
        check_output($sformatf("done_pos_%02h", v.din), done_at, FC - 1);
    endtask

    initial begin
        int n, busy_cycles, done_cycles;
        vecs[0] = '{8'h41, 1'b1};
        vecs[1] = '{8'h01, 1'b0};
        vecs[2] = '{8'hFF, 1'b1};
        vecs[3] = '{8'h00, 1'b1};
        vecs[4] = '{8'hC3, 1'b1};
        vecs[5] = '{8'h5A, 1'b1};

        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_output("reset_tx", 32'(tx_out), 32'd1);
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_done", 32'(done), 32'd0);
        mon_en = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) apply_stimulus(vecs[i]);

        // Held send: second frame must start after exactly one idle-high cycle
        wait_idle();
        din  = 8'h55;
        send = 1'b1;
        @(negedge clk);
        din = 8'hAA;
        n = 0;
        while (done !== 1'b1 && n < FC + 5) begin
            @(negedge clk);
            n++;
        end
        check_output("b2b_done_seen", 32'(done), 32'd1);
        @(negedge clk);
        check_output("b2b_gap_busy", 32'(busy), 32'd0);
        check_output("b2b_gap_line", 32'(tx_out), 32'd1);
        @(negedge clk);
        check_output("b2b_second_busy", 32'(busy), 32'd1);
        check_output("b2b_second_start", 32'(tx_out), 32'd0);
        send = 1'b0;

        // A request during DATA is dropped and the frame runs to full length
        wait_idle();
        din  = 8'h3C;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        busy_cycles = 0;
        for (int k = 0; k < FC + 3; k++) begin
            if (busy) busy_cycles++;
            if (k == 3 * B + 2) begin
                send = 1'b1;
                din  = 8'h99;
            end else if (k == 3 * B + 3) begin
                send = 1'b0;
            end
            @(negedge clk);
        end
        check_output("ignore_busy_len", busy_cycles, FC);

        // Reset during data bit 4 aborts the frame without a done pulse
        wait_idle();
        din  = 8'hA5;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        repeat (5 * B + 3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_output("abort_tx", 32'(tx_out), 32'd1);
        check_output("abort_busy", 32'(busy), 32'd0);
        check_output("abort_done", 32'(done), 32'd0);
        rst = 1'b1;
        done_cycles = 0;
        repeat (2 * B) begin
            if (done) done_cycles++;
            @(negedge clk);
        end
        check_output("abort_no_done", done_cycles, 0);
        apply_stimulus(vecs[5]);

        // Random requests, data churn and occasional resets against the model
        for (int c = 0; c < 3000; c++) begin
            send = ($urandom_range(0, 3) == 0);
            din  = 8'($urandom);
            rst  = ($urandom_range(0, 399) != 0);
            @(negedge clk);
        end
        rst  = 1'b1;
        send = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Synthesizable UART transmitter that serializes one byte per request into a start bit, eight LSB-first data bits, an optional parity bit and a stop bit on a single line. It drives the transmit pin of the top-level design and pairs with the team's UART receiver at the same baud rate and parity setting. A simple send/busy handshake paces the upstream logic, and a one-cycle `done` pulse marks the end of each frame.

## Interface
- `CLK_FREQUENCY`, 100_000_000: system clock frequency in Hz.
- `BAUD_RATE`, 19_200: line bit rate in bits per second.
- `PARITY`, 1: parity bit = `^din ^ PARITY`. 1 selects odd parity, 0 selects even.

- `clk`  in  1  system clock; every register updates on its rising edge.
- `rst`  in  1  synchronous, active-low reset. Sampled on the `clk` rising edge; a 0 resets the block.
- `send`  in  1  transmit request, sampled only while `busy`=0.
- `din`  in  8  byte to transmit, captured on the accepting edge.
- `busy`  out  1  high from request acceptance until the stop bit completes.
- `done`  out  1  one-cycle pulse on the last cycle of the stop bit.
- `tx_out`  out  1  serial line, idle high.

## Operation
- Derived constants:
  - BAUD_CLOCK_CYCLES = CLK_FREQUENCY / BAUD_RATE, using integer division (5208 at the defaults).
  - Baud counter width = $clog2(BAUD_CLOCK_CYCLES).
  - Bit index is a 3-bit counter.
- FSM states: IDLE, START, DATA, PARITY_BIT, STOP.
- IDLE:
  - `tx_out`=1, `busy`=0.
  - If `send`=1: latch `din` into the shift register, compute the parity bit, and go to START.
- START: `tx_out`=0 for BAUD_CLOCK_CYCLES cycles, then go to DATA with bit index 0.
- DATA:
  - `tx_out` = shift register bit 0, held for BAUD_CLOCK_CYCLES cycles.
  - Then shift right and increment the bit index.
  - After bit index 7 completes, go to PARITY_BIT.
- PARITY_BIT: `tx_out` = latched parity for BAUD_CLOCK_CYCLES cycles, then go to STOP.
- STOP:
  - `tx_out`=1 for BAUD_CLOCK_CYCLES cycles.
  - `done`=1 on the final cycle, then go to IDLE.
- The baud counter counts 0..BAUD_CLOCK_CYCLES-1 and clears on every state transition.
- `send` asserted while `busy`=1 is ignored, with no queuing. Changes to `din` mid-frame have no effect.
- Holding `send` high produces back-to-back frames. Each new frame is accepted in the single IDLE cycle after STOP.

## Timing
- Reset values: `tx_out`=1, `busy`=0, `done`=0, state IDLE, counters 0, shift register 0.
- Reset is fully synchronous. Asserting `rst`=0 mid-frame aborts the frame, and `tx_out` returns to 1 on that same edge. No partial completion occurs and no `done` pulse is generated.
- Acceptance latency:
  - `send` is sampled high on edge N in IDLE.
  - `tx_out` falls and `busy` rises on edge N.
  - Both become visible in the cycle after N.
- Every bit, including start and stop, occupies exactly BAUD_CLOCK_CYCLES clock cycles.
- Frame length:
  - With parity: 11 × BAUD_CLOCK_CYCLES cycles (57288 at the defaults).
  - Without parity: 10 × BAUD_CLOCK_CYCLES cycles.
- `busy` falls on the edge that ends STOP, coincident with the end of the `done` pulse.
- Minimum gap between frames is 1 IDLE cycle with `tx_out`=1.
- Reset has priority over `send`. `send`=1 together with `rst`=0 is ignored.

## Configuration
- `UART_TX_PARITY_EN`
  - Defined: the PARITY_BIT state is present and the frame is 11 bits, with parity = `^din ^ PARITY`.
  - Undefined: the PARITY_BIT state, the parity register and the parity logic are removed. DATA goes directly to STOP, the frame is 10 bits, and the `PARITY` parameter is unused.

## Test plan
Scenarios 1–5 assume `UART_TX_PARITY_EN` defined, `PARITY`=1 and default clock/baud, so one bit = 5208 cycles.

1. Send 0x41 → line reads 0, 1,0,0,0,0,0,1,0, parity 1, stop 1, sampled at each bit centre. `busy` is high for 57288 cycles, then `done` pulses once.
2. Send 0x01 → parity bit 0. Send 0xFF → parity bit 1. Send 0x00 → parity bit 1. A receiver model at `PARITY`=1 reports no parity or stop warnings for any of them.
3. Hold `send`=1 with `din`=0x55, switch `din` to 0xAA after acceptance, then release `send` after the second acceptance → two frames, 0x55 then 0xAA, separated by exactly 1 idle-high cycle.
4. Send 0x3C, then pulse `send` with `din`=0x99 during DATA → only 0x3C is transmitted and `busy` never drops early.
5. Send 0xA5 and assert `rst`=0 for 1 cycle during data bit 4 → `tx_out`=1 and `busy`=0 in the next cycle, no `done` pulse. A subsequent send of 0x5A transmits correctly.
6. With `UART_TX_PARITY_EN` undefined, send 0xC3 → 10-bit frame 0, 1,1,0,0,0,0,1,1, 1 lasting 52080 cycles, with `done` on the last cycle.
